// File: rtl/wb_cfg_sequencer_if.sv
// Wishbone master-side bus bundle for the config sequencer.
// Signal names follow the sequencer's point of view (o_* driven by the master).
interface wb_cfg_sequencer_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [15:0] o_wb_adr;
  logic [15:0] o_wb_data;
  logic        i_wb_ack;
  logic [15:0] i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data,
    input  i_wb_ack, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data,
    output i_wb_ack, i_wb_data
  );
endinterface

// File: rtl/wb_cfg_sequencer.sv
// Programs divisor, period, DC, then ctrl over Wishbone from one start pulse,
// optionally reads them all back; stalls bounded by an ack timeout.
module wb_cfg_sequencer #(
  parameter logic [15:0] base_adr        = 16'h0000,
  parameter logic [15:0] ctrl_spacing    = 16'd0,
  parameter logic [15:0] divisor_spacing = 16'd2,
  parameter logic [15:0] period_spacing  = 16'd4,
  parameter logic [15:0] DC_spacing      = 16'd6,
  parameter int          TIMEOUT         = 16,
  parameter bit          VERIFY          = 1'b1
) (
  input  logic                i_wb_clk,
  input  logic                i_wb_rst_n,
  input  logic                i_start,
  input  logic [15:0]         i_ctrl_val,
  input  logic [15:0]         i_divisor_val,
  input  logic [15:0]         i_period_val,
  input  logic [15:0]         i_dc_val,
  wb_cfg_sequencer_if.master  wb,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [15:0]         o_err_adr
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR, WGAP, RD, RGAP, DONE, FAIL} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0][15:0]  val_q, val_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [15:0]       adr_q, adr_d, dat_q, dat_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [15:0]       err_adr_q, err_adr_d;

  // Index order is the transfer order: 0=divisor, 1=period, 2=DC, 3=ctrl.
  logic [3:0][15:0]  start_vals;
  logic [1:0]        nxt_idx;
  logic [7:0]        cnt_inc;

  assign start_vals = {i_ctrl_val, i_dc_val, i_period_val, i_divisor_val};
  assign nxt_idx    = idx_q + 2'd1;
  assign cnt_inc    = cnt_q + 8'd1;

  function automatic logic [15:0] reg_adr(input logic [1:0] i);
    case (i)
      2'd0:    reg_adr = base_adr + divisor_spacing;
      2'd1:    reg_adr = base_adr + period_spacing;
      2'd2:    reg_adr = base_adr + DC_spacing;
      default: reg_adr = base_adr + ctrl_spacing;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    err_adr_d = err_adr_q;

    case (state_q)
      IDLE: begin
        cyc_d  = 1'b0;
        stb_d  = 1'b0;
        we_d   = 1'b0;
        busy_d = 1'b0;
        if (i_start) begin
          val_d     = start_vals;
          err_d     = 1'b0;
          err_adr_d = 16'h0000;
          idx_d     = 2'd0;
          cnt_d     = 8'd0;
          state_d   = WR;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = 1'b1;
          adr_d     = reg_adr(2'd0);
          dat_d     = start_vals[0];
          busy_d    = 1'b1;
        end
      end

      WR, RD: begin
        if ((wb.i_wb_ack && state_q == RD && wb.i_wb_data != val_q[idx_q]) ||
            (!wb.i_wb_ack && cnt_inc == TO)) begin
          err_d     = 1'b1;
          err_adr_d = adr_q;
          state_d   = FAIL;
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          we_d      = 1'b0;
          adr_d     = 16'h0000;
          dat_d     = 16'h0000;
        end else if (wb.i_wb_ack) begin
          // The write->read turnaround reuses WGAP so every transfer sees a gap.
          if (idx_q != 2'd3 || (state_q == WR && VERIFY)) begin
            state_d = (state_q == WR) ? WGAP : RGAP;
            stb_d   = 1'b0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            adr_d   = 16'h0000;
            dat_d   = 16'h0000;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WGAP: begin
        idx_d = nxt_idx;
        cnt_d = 8'd0;
        stb_d = 1'b1;
        adr_d = reg_adr(nxt_idx);
        if (idx_q == 2'd3) begin
          state_d = RD;
          we_d    = 1'b0;
          dat_d   = 16'h0000;
        end else begin
          state_d = WR;
          dat_d   = val_q[nxt_idx];
        end
      end

      RGAP: begin
        idx_d   = nxt_idx;
        cnt_d   = 8'd0;
        stb_d   = 1'b1;
        adr_d   = reg_adr(nxt_idx);
        state_d = RD;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= 8'd0;
      val_q     <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 16'h0000;
      dat_q     <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_adr_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      val_q     <= val_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
    end
  end

  assign wb.o_wb_cyc  = cyc_q;
  assign wb.o_wb_stb  = stb_q;
  assign wb.o_wb_we   = we_q;
  assign wb.o_wb_adr  = adr_q;
  assign wb.o_wb_data = dat_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_err_adr    = err_adr_q;

endmodule

// File: tb/tb_wb_cfg_sequencer.sv
// Bench: DUT0 (VERIFY=1) and DUT1 (VERIFY=0) against a mirroring Wishbone slave
// with stall / corrupt / always-ack modes; a transaction-level model gives expectations.
module tb_wb_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, start;
  logic [15:0] ctrl_v, div_v, per_v, dc_v;

  logic [1:0]  cyc_s, stb_s, we_s, busy_s, done_s, err_s, ack_s;
  logic [15:0] adr_s [2];
  logic [15:0] wdat_s [2];
  logic [15:0] rdata [2];
  logic [15:0] eadr_s [2];

  // slave controls
  logic [1:0]  ack_always, stall_en, stall_we, corrupt_en;
  logic [15:0] stall_adr [2];
  logic [15:0] corrupt_adr [2];
  logic [15:0] corrupt_val [2];
  logic [15:0] mem [2][16];

  wb_cfg_sequencer_if wb0();
  wb_cfg_sequencer_if wb1();

  wb_cfg_sequencer #(.TIMEOUT(16), .VERIFY(1'b1)) dut0 (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n[0]), .i_start(start[0]),
    .i_ctrl_val(ctrl_v), .i_divisor_val(div_v), .i_period_val(per_v), .i_dc_val(dc_v),
    .wb(wb0), .o_busy(busy_s[0]), .o_done(done_s[0]), .o_err(err_s[0]), .o_err_adr(eadr_s[0]));

  wb_cfg_sequencer #(.TIMEOUT(16), .VERIFY(1'b0)) dut1 (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n[1]), .i_start(start[1]),
    .i_ctrl_val(ctrl_v), .i_divisor_val(div_v), .i_period_val(per_v), .i_dc_val(dc_v),
    .wb(wb1), .o_busy(busy_s[1]), .o_done(done_s[1]), .o_err(err_s[1]), .o_err_adr(eadr_s[1]));

  assign cyc_s[0] = wb0.o_wb_cyc;   assign cyc_s[1] = wb1.o_wb_cyc;
  assign stb_s[0] = wb0.o_wb_stb;   assign stb_s[1] = wb1.o_wb_stb;
  assign we_s[0]  = wb0.o_wb_we;    assign we_s[1]  = wb1.o_wb_we;
  assign adr_s[0] = wb0.o_wb_adr;   assign adr_s[1] = wb1.o_wb_adr;
  assign wdat_s[0] = wb0.o_wb_data; assign wdat_s[1] = wb1.o_wb_data;
  assign wb0.i_wb_ack = ack_s[0];   assign wb1.i_wb_ack = ack_s[1];
  assign wb0.i_wb_data = rdata[0];  assign wb1.i_wb_data = rdata[1];

  always_comb begin
    for (int g = 0; g < 2; g++)
      rdata[g] = (corrupt_en[g] && adr_s[g] == corrupt_adr[g]) ? corrupt_val[g] : mem[g][adr_s[g][3:0]];
  end

  // slave + monitor
  int edge_n = 0;
  int stb_cnt [2] = '{0, 0};
  int pulse_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int done_edge [2] = '{0, 0};
  logic [1:0] stb_prev = 2'b00;
  logic [32:0] log0 [$];
  logic [32:0] log1 [$];

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    stb_prev <= stb_s;
    for (int g = 0; g < 2; g++) begin
      if (stb_s[g] && ack_s[g] && we_s[g]) mem[g][adr_s[g][3:0]] <= wdat_s[g];
      if (ack_always[g]) ack_s[g] <= 1'b1;
      else ack_s[g] <= stb_s[g] && !ack_s[g] &&
                       !(stall_en[g] && adr_s[g] == stall_adr[g] && we_s[g] == stall_we[g]);
      if (stb_s[g]) stb_cnt[g] <= stb_cnt[g] + 1;
      if (stb_s[g] && !stb_prev[g]) pulse_cnt[g] <= pulse_cnt[g] + 1;
      if (done_s[g]) begin
        done_cnt[g] <= done_cnt[g] + 1;
        done_edge[g] <= edge_n;
      end
    end
    if (stb_s[0] && ack_s[0]) log0.push_back({we_s[0], adr_s[0], we_s[0] ? wdat_s[0] : rdata[0]});
    if (stb_s[1] && ack_s[1]) log1.push_back({we_s[1], adr_s[1], we_s[1] ? wdat_s[1] : rdata[1]});
  end

  int n_chk = 0, n_pass = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [53:0] outs(input int g);
    return {cyc_s[g], stb_s[g], we_s[g], adr_s[g], wdat_s[g], busy_s[g], done_s[g], err_s[g], eadr_s[g]};
  endfunction

  typedef struct {
    int dut; bit aa; bit restart;
    logic [15:0] c, d, p, dc;
    bit st_en; bit st_we; logic [15:0] st_adr;
    bit cr_en; logic [15:0] cr_adr, cr_val;
    bit exp_err; logic [15:0] exp_eadr; int exp_done; int exp_pulses;
  } vec_t;

  // mode: 0 normal, 1 stall (adr, we), 2 corrupt readback (adr, val)
  function automatic vec_t mk(int dut, bit aa, int mode, logic [15:0] madr, bit mwe, logic [15:0] mval,
                              bit ee, logic [15:0] eadr, int drel, int pul);
    vec_t v;
    v.dut = dut; v.aa = aa; v.restart = 1'b0;
    v.c = 16'h0001; v.d = 16'h0004; v.p = 16'h0100; v.dc = 16'h0080;
    v.st_en = (mode == 1); v.st_we = mwe; v.st_adr = madr;
    v.cr_en = (mode == 2); v.cr_adr = madr; v.cr_val = mval;
    v.exp_err = ee; v.exp_eadr = eadr; v.exp_done = drel; v.exp_pulses = pul;
    return v;
  endfunction

  // Transaction-level reference: walk the planned register accesses in order.
  logic [32:0] exp_q [$];
  int m_pulses, m_stb, m_done;
  bit m_err;
  logic [15:0] m_eadr;

  task automatic model(input vec_t v);
    logic [15:0] vals [4];
    logic [15:0] offs [4];
    logic [15:0] d;
    int lat, n;
    bit stop;
    vals = '{v.d, v.p, v.dc, v.c};
    offs = '{16'd2, 16'd4, 16'd6, 16'd0};
    lat = v.aa ? 1 : 2;
    exp_q.delete();
    m_pulses = 0; m_stb = 0; m_done = -1; m_err = 0; m_eadr = 16'h0; n = 0; stop = 0;
    for (int ph = 0; ph < ((v.dut == 0) ? 2 : 1); ph++)
      for (int i = 0; i < 4; i++) begin
        if (!stop) begin
          m_pulses++;
          if (v.st_en && !v.aa && v.st_adr == offs[i] && v.st_we == (ph == 0)) begin
            m_stb += 16; m_err = 1; m_eadr = offs[i]; stop = 1;
          end else begin
            m_stb += lat;
            d = (ph == 0) ? vals[i] : ((v.cr_en && v.cr_adr == offs[i]) ? v.cr_val : vals[i]);
            exp_q.push_back({ph == 0, offs[i], d});
            n++;
            if (d != vals[i]) begin m_err = 1; m_eadr = offs[i]; stop = 1; end
          end
        end
      end
    if (!m_err) m_done = n * (lat + 1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int g, t0, qb, sb, pb, db, got_n;
    logic [32:0] got;
    g = v.dut;
    model(v);
    @(negedge clk);
    ctrl_v = v.c; div_v = v.d; per_v = v.p; dc_v = v.dc;
    ack_always[g] = v.aa; stall_en[g] = v.st_en; stall_we[g] = v.st_we; stall_adr[g] = v.st_adr;
    corrupt_en[g] = v.cr_en; corrupt_adr[g] = v.cr_adr; corrupt_val[g] = v.cr_val;
    @(negedge clk);
    qb = (g == 0) ? log0.size() : log1.size();
    sb = stb_cnt[g]; pb = pulse_cnt[g]; db = done_cnt[g];
    start[g] = 1'b1; t0 = edge_n;
    @(negedge clk);
    start[g] = 1'b0;
    check({tag, "_start"}, {busy_s[g], err_s[g], eadr_s[g]}, {1'b1, 1'b0, 16'h0});
    ctrl_v = 16'($urandom); div_v = 16'($urandom); per_v = 16'($urandom); dc_v = 16'($urandom);
    for (int i = 0; i < 300 && busy_s[g]; i++) begin
      start[g] = v.restart && (i == 4);
      @(negedge clk);
    end
    start[g] = 1'b0;
    check({tag, "_busy_end"}, busy_s[g], 1'b0);
    repeat (3) @(negedge clk);
    check({tag, "_err"}, {err_s[g], eadr_s[g]}, {v.exp_err, v.exp_eadr});
    check({tag, "_done_cnt"}, done_cnt[g] - db, v.exp_err ? 0 : 1);
    if (!v.exp_err) check({tag, "_done_at"}, done_edge[g] - t0, v.exp_done);
    check({tag, "_pulses"}, pulse_cnt[g] - pb, v.exp_pulses);
    check({tag, "_stb_cycles"}, stb_cnt[g] - sb, m_stb);
    got_n = ((g == 0) ? log0.size() : log1.size()) - qb;
    check({tag, "_xfers"}, got_n, exp_q.size());
    for (int i = 0; i < got_n && i < exp_q.size(); i++) begin
      got = (g == 0) ? log0[qb + i] : log1[qb + i];
      check({tag, "_xfer"}, got, exp_q[i]);
    end
  endtask

  vec_t tbl [8];
  vec_t rv;
  int pb0;

  initial begin
    rst_n = 2'b00; start = 2'b00;
    ctrl_v = 0; div_v = 0; per_v = 0; dc_v = 0;
    ack_always = 0; stall_en = 0; stall_we = 0; corrupt_en = 0;
    for (int g = 0; g < 2; g++) begin
      stall_adr[g] = 0; corrupt_adr[g] = 0; corrupt_val[g] = 0;
      for (int a = 0; a < 16; a++) mem[g][a] = 16'h0;
    end

    tbl[0] = mk(0, 0, 0, 16'h0, 0, 16'h0,    0, 16'h0,    24, 8);
    tbl[1] = mk(1, 0, 0, 16'h0, 0, 16'h0,    0, 16'h0,    12, 4);
    tbl[2] = mk(0, 0, 1, 16'h4, 1, 16'h0,    1, 16'h0004, -1, 2);
    tbl[3] = mk(0, 0, 2, 16'h6, 0, 16'h00FF, 1, 16'h0006, -1, 7);
    tbl[4] = mk(0, 1, 0, 16'h0, 0, 16'h0,    0, 16'h0,    16, 8);
    tbl[4].restart = 1'b1;
    tbl[5] = mk(1, 1, 0, 16'h0, 0, 16'h0,    0, 16'h0,     8, 4);
    tbl[6] = mk(1, 0, 1, 16'h0, 1, 16'h0,    1, 16'h0000, -1, 4);
    tbl[7] = mk(0, 0, 1, 16'h2, 0, 16'h0,    1, 16'h0002, -1, 5);

    repeat (3) @(negedge clk);
    check("reset_dut0", outs(0), '0);
    check("reset_dut1", outs(1), '0);
    rst_n = 2'b11;

    // reset in the middle of the DC write abandons the sequence
    @(negedge clk);
    ctrl_v = 16'h0001; div_v = 16'h0004; per_v = 16'h0100; dc_v = 16'h0080;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_wr_dc", {stb_s[0], we_s[0], adr_s[0], wdat_s[0]}, {1'b1, 1'b1, 16'h0006, 16'h0080});
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    check("mid_rst_outs", outs(0), '0);
    pb0 = pulse_cnt[0];
    repeat (8) @(negedge clk);
    check("mid_rst_abandon", {pulse_cnt[0] - pb0, busy_s[0]}, {32'd0, 1'b0});

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      int mode, idx;
      logic [15:0] offs [4];
      offs = '{16'd2, 16'd4, 16'd6, 16'd0};
      idx = $urandom_range(0, 3);
      rv = mk($urandom_range(0, 1), 0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0);
      mode = $urandom_range(0, 3);
      rv.c = 16'($urandom); rv.d = 16'($urandom); rv.p = 16'($urandom); rv.dc = 16'($urandom);
      if (mode == 1) rv.aa = 1'b1;
      if (mode == 2) begin
        rv.st_en = 1'b1; rv.st_adr = offs[idx];
        rv.st_we = (rv.dut == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (mode == 3 && rv.dut == 0) begin
        rv.cr_en = 1'b1; rv.cr_adr = offs[idx];
        rv.cr_val = ($urandom_range(0, 3) == 0) ? ((idx == 0) ? rv.d : (idx == 1) ? rv.p : (idx == 2) ? rv.dc : rv.c)
                                                : 16'($urandom);
      end
      model(rv);
      rv.exp_err = m_err; rv.exp_eadr = m_eadr; rv.exp_done = m_done; rv.exp_pulses = m_pulses;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
